// File: rtl/des_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// des_job_scheduler_if : request, DES-core and response signal bundle
// Rev 1.0
// ============================================================================
interface des_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_data;
  logic [64*NREQ-1:0]   req_key;
  logic [NREQ-1:0]      req_decrypt;
  logic                 core_start;
  logic [63:0]          core_data;
  logic [63:0]          core_key;
  logic                 core_decrypt;
  logic                 core_done;
  logic [63:0]          core_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [63:0]          rsp_data;
  logic                 rsp_error;
  logic                 busy;

  modport slave (
    input  req_valid, req_data, req_key, req_decrypt, core_done, core_result, rsp_ready,
    output req_ready, core_start, core_data, core_key, core_decrypt,
           rsp_valid, rsp_id, rsp_data, rsp_error, busy
  );

  modport master (
    output req_valid, req_data, req_key, req_decrypt, core_done, core_result, rsp_ready,
    input  req_ready, core_start, core_data, core_key, core_decrypt,
           rsp_valid, rsp_id, rsp_data, rsp_error, busy
  );
endinterface
`default_nettype wire

// File: rtl/des_job_scheduler.sv
`default_nettype none
// ============================================================================
// des_job_scheduler : round-robin front end sharing one iterative DES core
// Rev 1.0
// ============================================================================
module des_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31
) (
  input wire                 clk,
  input wire                 reset,
  des_job_scheduler_if.slave bus
);

  localparam int                c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [ID_W-1:0]    c_rr_init  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic               r_core_start;
  logic [63:0]        r_core_data;
  logic [63:0]        r_core_key;
  logic               r_core_decrypt;
  logic               r_rsp_valid;
  logic [63:0]        r_rsp_data;
  logic               r_rsp_error;
  logic               r_busy;

  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_id;
  logic [NREQ-1:0]    w_grant_onehot;
  logic [63:0]        w_sel_data;
  logic [63:0]        w_sel_key;
  logic               w_sel_dec;

  assign w_grant_any = |bus.req_valid;

  // Lowest rotated offset from rr_ptr+1 wins; offset 0 is the requester just after the last served one.
  always_comb begin : p_arb
    int best;
    int off;
    best           = NREQ;
    off            = 0;
    w_grant_id     = '0;
    w_grant_onehot = '0;
    w_sel_data     = '0;
    w_sel_key      = '0;
    w_sel_dec      = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      off = (j + 2 * NREQ - 1 - int'(r_rr_ptr)) % NREQ;
      if (bus.req_valid[j] && (off < best)) begin
        best              = off;
        w_grant_id        = ID_W'(j);
        w_grant_onehot    = '0;
        w_grant_onehot[j] = 1'b1;
        w_sel_data        = bus.req_data[j*64 +: 64];
        w_sel_key         = bus.req_key[j*64 +: 64];
        w_sel_dec         = bus.req_decrypt[j];
      end
    end
  end

  // Accept is combinational so the requester's payload is latched in the same cycle it sees ready.
  assign bus.req_ready = (reset && (r_state == S_IDLE) && w_grant_any) ? w_grant_onehot : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rr_ptr       <= c_rr_init;
      r_id           <= '0;
      r_core_start   <= 1'b0;
      r_core_data    <= '0;
      r_core_key     <= '0;
      r_core_decrypt <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_id           <= w_grant_id;
            r_core_data    <= w_sel_data;
            r_core_key     <= w_sel_key;
            r_core_decrypt <= w_sel_dec;
            r_core_start   <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_core_start <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (bus.core_done) begin
            r_rsp_data  <= bus.core_result;
            r_rsp_error <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rr_ptr    <= r_id;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_core_start <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_start   = r_core_start;
  assign bus.core_data    = r_core_data;
  assign bus.core_key     = r_core_key;
  assign bus.core_decrypt = r_core_decrypt;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_id;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_error    = r_rsp_error;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_des_job_scheduler.sv
`default_nettype none
// ============================================================================
// tb_des_job_scheduler : vector table plus hand sequences against a DES core model
// Rev 1.0
// ============================================================================
module tb_des_job_scheduler;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 31;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  des_job_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  des_job_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic [63:0] key;
    logic        dec;
    int          k;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[7];
  logic [63:0] pay_data[NREQ];
  logic [63:0] pay_key[NREQ];
  logic [NREQ-1:0] pay_dec;

  // Stand-in for the DES core: the textbook vector maps to its known ciphertext.
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k, input logic dec);
    if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1 && !dec)
      return 64'h85E813540F0AB405;
    return {d[31:0], d[63:32]} ^ (k << 1) ^ {64{dec}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always_comb begin
    bus.req_data    = '0;
    bus.req_key     = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*64 +: 64] = pay_data[i];
      bus.req_key[i*64 +: 64]  = pay_key[i];
    end
    bus.req_decrypt = pay_dec;
  end

  int          cm_k = 0;
  int          cm_left;
  logic        cm_done;
  logic [63:0] cm_result;
  logic        tb_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cm_left   <= 0;
      cm_done   <= 1'b0;
      cm_result <= '0;
    end else begin
      cm_done <= 1'b0;
      if (bus.core_start) begin
        cm_result <= core_fn(bus.core_data, bus.core_key, bus.core_decrypt);
        if (cm_k == 1) cm_done <= 1'b1;
        cm_left <= (cm_k > 1) ? cm_k - 1 : 0;
      end else if (cm_left > 0) begin
        cm_left <= cm_left - 1;
        if (cm_left == 1) cm_done <= 1'b1;
      end
    end
  end

  assign bus.core_done   = cm_done | tb_done;
  assign bus.core_result = cm_result;

  int gcyc = -10;
  int gid = 0;
  int n_grants = 0;
  int n_rsp = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.req_ready != '0) begin
        check("grant_onehot_idle", {62'd0, bus.busy, $onehot(bus.req_ready)}, 64'd1);
        gcyc = cyc;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
        n_grants++;
      end
      if (bus.core_start) begin
        check("start_latency", cyc, gcyc + 1);
        check("core_data", bus.core_data, pay_data[gid]);
        check("core_key", bus.core_key, pay_key[gid]);
        check("core_decrypt", bus.core_decrypt, pay_dec[gid]);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d data %h err %0d, no response required",
                   bus.rsp_id, bus.rsp_data, bus.rsp_error);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_error", bus.rsp_error, e.err);
        end
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int id, output int t);
    t = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        t = cyc;
        break;
      end
    end
    n_tests++;
    if (t < 0) begin
      n_fail++;
      $display("FAIL grant_wait: requester %0d got no req_ready, required within 80 cycles", id);
    end
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t = cyc;
        break;
      end
    end
    n_tests++;
    if (t < 0) begin
      n_fail++;
      $display("FAIL rsp_wait: got no rsp_valid, required within 80 cycles");
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {57'd0, bus.busy, bus.core_start, bus.rsp_valid, bus.rsp_error, bus.core_decrypt,
          bus.rsp_id}, 64'd0);
    check({tag, "_ready"}, bus.req_ready, 64'd0);
    check({tag, "_core_data"}, bus.core_data, 64'd0);
    check({tag, "_core_key"}, bus.core_key, 64'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r, h, g0, n0, exp_lat;
    logic [63:0] hold_data;

    reset         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tb_done       = 1'b0;
    pay_dec       = '0;
    for (int i = 0; i < NREQ; i++) begin
      pay_data[i] = '0;
      pay_key[i]  = '0;
    end

    vt[0] = '{id:0, data:64'h0123456789ABCDEF, key:64'h133457799BBCDFF1, dec:1'b0, k:16,
              exp_data:64'h85E813540F0AB405, exp_err:1'b0};
    vt[1] = '{id:1, data:64'hFEDCBA9876543210, key:64'h0E329232EA6D0D73, dec:1'b1, k:1,
              exp_data:core_fn(64'hFEDCBA9876543210, 64'h0E329232EA6D0D73, 1'b1), exp_err:1'b0};
    vt[2] = '{id:3, data:64'h1122334455667788, key:64'hAABB09123456CDEF, dec:1'b0, k:5,
              exp_data:core_fn(64'h1122334455667788, 64'hAABB09123456CDEF, 1'b0), exp_err:1'b0};
    // done on the very last WAIT cycle: the result must win over the watchdog
    vt[3] = '{id:2, data:64'hDEADBEEF0BADF00D, key:64'h0101010101010101, dec:1'b1, k:TIMEOUT,
              exp_data:core_fn(64'hDEADBEEF0BADF00D, 64'h0101010101010101, 1'b1), exp_err:1'b0};
    vt[4] = '{id:1, data:64'h0000000000000001, key:64'hFFFFFFFFFFFFFFFF, dec:1'b0, k:0,
              exp_data:64'd0, exp_err:1'b1};
    vt[5] = '{id:0, data:64'h8000000000000000, key:64'h3B3898371520F75E, dec:1'b1, k:TIMEOUT + 1,
              exp_data:64'd0, exp_err:1'b1};
    vt[6] = '{id:3, data:64'h0123456789ABCDEF, key:64'h133457799BBCDFF1, dec:1'b1, k:17,
              exp_data:core_fn(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1), exp_err:1'b0};

    repeat (2) @(negedge clk);
    check_quiet("reset");
    drive_slot();
    reset = 1'b1;
    @(negedge clk);
    check_quiet("post_reset_idle");

    // Single jobs from the table: payload, result and latency.
    foreach (vt[v]) begin
      drive_slot();
      pay_data[vt[v].id] = vt[v].data;
      pay_key[vt[v].id]  = vt[v].key;
      pay_dec[vt[v].id]  = vt[v].dec;
      cm_k               = vt[v].k;
      bus.rsp_ready      = 1'b1;
      sbq.push_back('{id:2'(vt[v].id), data:vt[v].exp_data, err:vt[v].exp_err});
      bus.req_valid[vt[v].id] = 1'b1;
      wait_grant(vt[v].id, t);
      drive_slot();
      bus.req_valid[vt[v].id] = 1'b0;
      wait_rsp(r);
      exp_lat = (vt[v].k >= 1 && vt[v].k <= TIMEOUT) ? vt[v].k + 2 : TIMEOUT + 2;
      if (t >= 0 && r >= 0) check("vec_latency", r - t, exp_lat);
    end

    // All requesters held valid: service order follows the rotation.
    drive_slot();
    cm_k = 3;
    g0   = n_grants;
    n0   = n_rsp;
    for (int i = 0; i < 5; i++) begin
      int id;
      id = i % NREQ;
      sbq.push_back('{id:2'(id), data:core_fn(pay_data[id], pay_key[id], pay_dec[id]), err:1'b0});
    end
    bus.req_valid = '1;
    for (int i = 0; i < 5; i++) wait_grant(i % NREQ, t);
    drive_slot();
    bus.req_valid = '0;
    wait_rsp(r);
    @(negedge clk);
    check("rr_grant_count", n_grants - g0, 5);
    check("rr_rsp_count", n_rsp - n0, 5);

    // Watchdog abort, then the still-pending requester is served right after the handshake.
    drive_slot();
    cm_k = 0;
    sbq.push_back('{id:2'd1, data:64'd0, err:1'b1});
    sbq.push_back('{id:2'd3, data:core_fn(pay_data[3], pay_key[3], pay_dec[3]), err:1'b0});
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    wait_grant(1, t);
    drive_slot();
    bus.req_valid[1] = 1'b0;
    wait_rsp(r);
    if (t >= 0 && r >= 0) check("timeout_latency", r - t, TIMEOUT + 2);
    cm_k = 4;
    wait_grant(3, t);
    if (t >= 0 && r >= 0) check("next_grant_after_abort", t, r + 1);
    drive_slot();
    bus.req_valid[3] = 1'b0;
    wait_rsp(r);
    if (t >= 0 && r >= 0) check("post_abort_latency", r - t, 6);

    // Consumer back-pressure: response frozen, nothing else issued.
    drive_slot();
    cm_k          = 2;
    bus.rsp_ready = 1'b0;
    hold_data     = core_fn(pay_data[2], pay_key[2], pay_dec[2]);
    sbq.push_back('{id:2'd2, data:hold_data, err:1'b0});
    sbq.push_back('{id:2'd0, data:core_fn(pay_data[0], pay_key[0], pay_dec[0]), err:1'b0});
    bus.req_valid[2] = 1'b1;
    wait_grant(2, t);
    drive_slot();
    bus.req_valid[2] = 1'b0;
    bus.req_valid[0] = 1'b1;
    wait_rsp(r);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1'b1);
      check("hold_rsp_id", bus.rsp_id, 2'd2);
      check("hold_rsp_data", bus.rsp_data, hold_data);
      check("hold_quiet", {bus.rsp_error, bus.core_start, bus.req_ready}, 6'd0);
    end
    drive_slot();
    h = cyc;
    bus.rsp_ready = 1'b1;
    wait_grant(0, t);
    if (t >= 0) check("grant_after_hold", t, h + 1);
    drive_slot();
    bus.req_valid[0] = 1'b0;
    wait_rsp(r);

    // Reset while the core is busy: job dropped, requester 0 first afterwards.
    drive_slot();
    cm_k = 0;
    bus.req_valid[1] = 1'b1;
    wait_grant(1, t);
    drive_slot();
    bus.req_valid[1] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset            = 1'b0;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    #1;
    check_quiet("mid_reset");
    pay_data[0] = 64'h0123456789ABCDEF;
    pay_key[0]  = 64'h133457799BBCDFF1;
    pay_dec[0]  = 1'b0;
    cm_k        = 16;
    sbq.push_back('{id:2'd0, data:64'h85E813540F0AB405, err:1'b0});
    sbq.push_back('{id:2'd3, data:core_fn(pay_data[3], pay_key[3], pay_dec[3]), err:1'b0});
    repeat (2) @(negedge clk);
    check("in_reset_rsp_valid", bus.rsp_valid, 1'b0);
    drive_slot();
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_priority", bus.req_ready, 4'b0001);
    drive_slot();
    bus.req_valid[0] = 1'b0;
    wait_grant(3, t);
    drive_slot();
    bus.req_valid[3] = 1'b0;
    wait_rsp(r);
    if (t >= 0 && r >= 0) check("post_reset_latency", r - t, 18);

    // Stray done while idle must not start anything.
    drive_slot();
    tb_done = 1'b1;
    drive_slot();
    tb_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done_ignored", {bus.busy, bus.rsp_valid, bus.core_start}, 3'd0);
    end

    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
